// File: rtl/irq_stim_pkg.sv
// Shared types, default widths and packed-field helpers for the irq stimulus generator.
package irq_stim_pkg;

  // Default widths used by the top-level parameters
  localparam int unsigned DefNumCh = 4;
  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefLenW  = 4;
  localparam int unsigned DefCntW  = 4;

  // Per-channel sequencer state
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StPulse = 2'd2
  } state_e;

  // LSB position of channel 'ch' inside a packed vector of 'width'-bit fields
  function automatic int unsigned field_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/irq_stim_chan.sv
// One trigger channel: IDLE/WAIT/PULSE sequencer, delay/length counter, re-arm flag and
// saturating fire counter.
module irq_stim_chan
  import irq_stim_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned LEN_W  = DefLenW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ch_en,
  input  logic [ADDR_W-1:0] match_addr,
  input  logic [LEN_W-1:0]  pulse_len,
  input  logic [LEN_W-1:0]  delay,
  input  logic [CNT_W-1:0]  fire_limit,
  input  logic              clear,
  output logic              irq,
  output logic              irq_next,
  output logic [CNT_W-1:0]  fire_cnt,
  output logic              done
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   fire_cnt_q, fire_cnt_d;
  logic               irq_q, irq_d;

  logic               addr_hit;
  logic               below_limit;
  logic               trigger;

  assign addr_hit    = (addr == match_addr);
  assign below_limit = (fire_limit == '0) || (fire_cnt_q < fire_limit);
  // armed_q is the pre-edge value, so a PC parked on the match address cannot re-fire
  assign trigger     = (state_q == StIdle) && ch_en && armed_q && addr_hit && below_limit;

  // State register: all channel state, cleared asynchronously on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      len_q      <= '0;
      armed_q    <= 1'b1;
      fire_cnt_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      armed_q    <= armed_d;
      fire_cnt_q <= fire_cnt_d;
      irq_q      <= irq_d;
    end
  end

  // Next-state: trigger/latch in IDLE, count down in WAIT and PULSE; clear wins over all
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    armed_d    = armed_q;
    fire_cnt_d = fire_cnt_q;

    if (clear) begin
      state_d    = StIdle;
      cnt_d      = '0;
      len_d      = '0;
      armed_d    = 1'b1;
      fire_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            // Config is latched so later changes cannot disturb this operation
            len_d   = pulse_len;
            armed_d = 1'b0;
            if (fire_cnt_q != '1) begin
              fire_cnt_d = fire_cnt_q + CNT_W'(1);
            end
            if (delay == '0) begin
              state_d = StPulse;
              cnt_d   = pulse_len;
            end else begin
              state_d = StWait;
              cnt_d   = delay - LEN_W'(1);
            end
          end else if (!armed_q && !addr_hit) begin
            armed_d = 1'b1;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_d = StPulse;
            cnt_d   = len_q;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
        StPulse: begin
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Outputs: irq follows the next state so it is high exactly while in PULSE
  always_comb begin
    irq_d    = (state_d == StPulse);
    irq_next = irq_d;
    irq      = irq_q;
    fire_cnt = fire_cnt_q;
    done     = (fire_limit != '0) && (fire_cnt_q >= fire_limit);
  end

endmodule

// File: rtl/irq_stim_gen.sv
// Multi-channel interrupt stimulus generator: slices packed config per channel and
// registers the OR of all interrupt lines.
module irq_stim_gen
  import irq_stim_pkg::*;
#(
  parameter int unsigned NUM_CH = DefNumCh,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned LEN_W  = DefLenW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*ADDR_W-1:0] match_addr,
  input  logic [NUM_CH*LEN_W-1:0]  pulse_len,
  input  logic [NUM_CH*LEN_W-1:0]  delay,
  input  logic [NUM_CH*CNT_W-1:0]  fire_limit,
  input  logic                     clear,
  output logic [NUM_CH-1:0]        irq,
  output logic                     irq_any,
  output logic [NUM_CH*CNT_W-1:0]  fire_cnt,
  output logic [NUM_CH-1:0]        done
);

  logic [NUM_CH-1:0] irq_next;
  logic              irq_any_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    localparam int unsigned AddrLsb = field_lsb(i, ADDR_W);
    localparam int unsigned LenLsb  = field_lsb(i, LEN_W);
    localparam int unsigned CntLsb  = field_lsb(i, CNT_W);

    irq_stim_chan #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .ch_en      (ch_en[i]),
      .match_addr (match_addr[AddrLsb +: ADDR_W]),
      .pulse_len  (pulse_len[LenLsb +: LEN_W]),
      .delay      (delay[LenLsb +: LEN_W]),
      .fire_limit (fire_limit[CntLsb +: CNT_W]),
      .clear      (clear),
      .irq        (irq[i]),
      .irq_next   (irq_next[i]),
      .fire_cnt   (fire_cnt[CntLsb +: CNT_W]),
      .done       (done[i])
    );
  end

  // irq_any built from next irq values so it lines up with the per-channel registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_any_q <= 1'b0;
    end else begin
      irq_any_q <= |irq_next;
    end
  end

  assign irq_any = irq_any_q;

endmodule

// File: doc/irq_stim_gen.md
Name: irq_stim_gen

Overview:
- Parametrised multi-channel interrupt stimulus generator for P7 CPU benches and on-board self-test.
- Watches the CPU macro-PC (`addr`).
- When a channel's match address is hit, the channel drives its interrupt line for a programmable number of cycles, after an optional programmable delay.
- Channels have fire limits and re-arm only after the PC has left the match address, so a stalled PC does not re-trigger.

Parameters:
- NUM_CH, 4: number of independent trigger channels.
- ADDR_W, 32: width of `addr` and of each match address.
- LEN_W, 4: width of the pulse-length and delay fields.
- CNT_W, 4: width of the per-channel fire counter and fire limit.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  ADDR_W  current macro-PC from the CPU.
- ch_en  in  NUM_CH  per-channel enable.
- match_addr  in  NUM_CH*ADDR_W  packed match addresses; channel i at [i*ADDR_W +: ADDR_W].
- pulse_len  in  NUM_CH*LEN_W  irq high time minus 1, in cycles.
- delay  in  NUM_CH*LEN_W  cycles from match to irq rise; 0 means irq rises on the match edge.
- fire_limit  in  NUM_CH*CNT_W  maximum number of fires; 0 means unlimited.
- clear  in  1  synchronous soft clear of all channels.
- irq  out  NUM_CH  per-channel interrupt, registered.
- irq_any  out  1  OR of `irq`, registered.
- fire_cnt  out  NUM_CH*CNT_W  fires so far per channel; saturates at all-ones.
- done  out  NUM_CH  channel has reached a nonzero fire_limit.

Behaviour:
- Reset (reset=0, asynchronous), every channel:
  - state=IDLE, armed=1, cnt=0, fire_cnt=0.
  - irq=0, irq_any=0, done=0.
- `clear`=1 at an edge: same values as reset, applied synchronously. Clear overrides every other event in that cycle.
- Per-channel FSM has three states: IDLE, WAIT, PULSE.
- Trigger condition, sampled at edge T in IDLE: ch_en & armed & addr==match_addr & (fire_limit==0 | fire_cnt<fire_limit).
- On trigger:
  - Latch pulse_len and delay into the channel; later config changes do not affect an operation in progress.
  - Set armed=0 and increment fire_cnt (saturating).
  - delay==0: go to PULSE, cnt=pulse_len; irq=1 after edge T.
  - delay=d>0: go to WAIT, cnt=d-1.
- WAIT, each edge: if cnt==0, go to PULSE with cnt=latched pulse_len and irq=1; otherwise decrement cnt.
  - Result: irq rises after edge T+d.
- PULSE, each edge: if cnt==0, go to IDLE with irq=0; otherwise decrement cnt.
  - Result: irq is high for exactly pulse_len+1 cycles.
- Address matches during WAIT or PULSE are ignored.
- Re-arm: in IDLE with armed=0, armed becomes 1 at any edge where addr!=match_addr.
  - A trigger needs armed=1 before that edge, so leave-and-return is required for each fire.
- ch_en deasserted in WAIT or PULSE: the operation completes; ch_en only gates new triggers.
- done[i]=1 when fire_limit!=0 and fire_cnt>=fire_limit. It updates in the same cycle as fire_cnt.
- irq_any is registered as the OR of the next irq values, so it is cycle-aligned with `irq`.
- Channels are fully independent. Several channels may fire on the same address in the same cycle.
- Reset asserted mid-operation: irq drops to 0 immediately, without waiting for a clock edge.

Decomposition:
- Package `irq_stim_pkg`:
  - state enum {IDLE, WAIT, PULSE};
  - default width constants;
  - helper functions for packed-field slicing.
- Sub-module `irq_stim_chan`: one channel's FSM, counters, armed flag and fire counter.
  - irq_stim_gen instantiates it NUM_CH times in a generate loop.
  - irq_stim_gen itself contains only the slicing and the irq_any register.

Test Plan:
- Ch0: match=0x00003020, delay=0, pulse_len=5, limit=1. addr=0x3020 for 1 cycle at edge T.
  - irq[0] high after T through T+6, i.e. 6 cycles; fire_cnt[0]=1, done[0]=1.
  - Second visit to 0x3020: no pulse.
- Ch0: delay=1, pulse_len=5. Match at edge T.
  - irq[0] low after T, rises after T+1, high 6 cycles.
- Stall: limit=0, addr held at 0x3020 for 20 cycles.
  - Exactly one 6-cycle pulse.
  - addr -> 0x3024 then back to 0x3020: second pulse; fire_cnt=2.
- Ch0 and ch1 both match 0x4198, pulse_len 2 and 5.
  - irq[0] high 3 cycles, irq[1] high 6 cycles, starting in the same cycle.
  - irq_any high 6 cycles.
- Mid-pulse reset: reset=0 at the 3rd cycle of a pulse.
  - irq, irq_any and fire_cnt read 0 immediately.
  - After reset release: armed again; next match fires.
- Mid-pulse config change: pulse_len changed 5 -> 1 and ch_en -> 0 during PULSE.
  - The pulse still lasts 6 cycles.
- Clear: clear=1 during WAIT.
  - irq never rises; state returns to IDLE; fire_cnt=0.
